operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Parametrised successor to the fixed 4-bit x 8-beat operand load front-end of the ECC top level.
- Collects NUM_OPS operands of DATA_W bits each over narrow CHUNK_W-bit input lanes, one chunk per operand per accepted beat.
- Uses a valid/ready handshake and a selectable chunk order, and supports abort.
- Presents the assembled operands (Px, Py, prime, a, k, ...) to Control and pulses o_load_done when the operand set is complete.

Parameters:
- DATA_W, 32: operand width in bits. Must be a multiple of CHUNK_W.
- CHUNK_W, 4: chunk width per operand lane.
- NUM_OPS, 5: number of operands loaded in parallel.
- MSB_FIRST, 0: 0 = first beat fills bits [CHUNK_W-1:0]; 1 = first beat fills the top chunk.
- BEATS, DATA_W/CHUNK_W (derived localparam): beats per load.
- CNT_W, clog2(BEATS+1) (derived localparam): beat counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  begin a load; honoured only in IDLE.
- i_abort  in  1  cancel an in-progress load.
- i_valid  in  1  i_chunk holds a valid beat.
- i_chunk  in  NUM_OPS*CHUNK_W  one chunk per operand; lane j is bits [j*CHUNK_W +: CHUNK_W].
- o_ready  out  1  beat is accepted this cycle when i_valid && o_ready.
- o_busy  out  1  high in LOAD and DONE.
- o_beat_cnt  out  CNT_W  beats accepted in the current load.
- o_ops  out  NUM_OPS*DATA_W  assembled operands; operand j is bits [j*DATA_W +: DATA_W].
- o_load_done  out  1  single-cycle pulse: operand set complete.
- o_start_err  out  1  sticky; set when i_start arrives while busy; cleared by the next accepted start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (i_rst_n=0, any state, any time):
  - state=IDLE; o_ops=0, o_beat_cnt=0, o_ready=0, o_busy=0, o_load_done=0, o_start_err=0.
  - Takes effect immediately, independent of the clock.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - o_ready=0, o_busy=0; o_ops holds its last value.
  - i_start=1 -> next cycle LOAD, o_ops cleared to 0, o_beat_cnt=0, o_start_err=0.
  - i_valid in IDLE is ignored.
- LOAD:
  - o_ready=1, o_busy=1.
  - On i_valid=1, beat index n = o_beat_cnt. For each lane j:
    - MSB_FIRST=0: operand j chunk n (bits [n*CHUNK_W +: CHUNK_W]) <= lane j.
    - MSB_FIRST=1: operand j chunk BEATS-1-n <= lane j.
    - o_beat_cnt increments.
  - On acceptance of beat BEATS-1 -> next cycle DONE; o_beat_cnt=BEATS.
  - i_valid=0 stalls with no timeout: state and data hold.
- DONE:
  - Lasts exactly one cycle: o_load_done=1, o_ready=0, o_busy=1.
  - Next cycle: IDLE, o_beat_cnt=0.
  - o_ops stays stable from DONE until the next accepted start.
- Latency: o_load_done is asserted the cycle after the final beat is accepted. Minimum load is 1 (start) + BEATS + 1 (DONE) cycles.
- Abort:
  - i_abort=1 in LOAD -> next cycle IDLE, o_ops=0, o_beat_cnt=0, no o_load_done.
  - Abort on the same cycle as the final beat: abort wins, no done pulse.
  - Abort in IDLE or DONE has no effect.
- Start while busy (LOAD or DONE):
  - Ignored; sets o_start_err.
  - Start plus abort in LOAD: abort taken, start ignored, o_start_err set.
- Start on the cycle after DONE (IDLE) is legal; back-to-back loads need no gap beyond DONE.
- All outputs are registered; no combinational path from inputs to outputs except o_ready, which is state-decoded only.

Test Plan:
- Defaults (32/4/5, LSB-first): start, then 8 beats of lane0 = 8,7,6,5,4,3,2,1 (beat 0 first) -> operand0 = 0x12345678, o_load_done pulses exactly once, 10 cycles after start; o_beat_cnt reads 8 during DONE, then 0.
- MSB_FIRST=1, same beats -> operand0 = 0x87654321. Other lanes constant 0xF -> 0xFFFFFFFF. Lane independence checked with lane4 = beat index (0..7): LSB-first build yields 0x76543210.
- Stall: insert 3 idle (i_valid=0) cycles after beat 2 -> identical o_ops; done is 3 cycles later; o_beat_cnt holds 3 during the stall.
- Abort on beat 5 -> IDLE next cycle, o_ops=0, no done pulse. Abort together with beat 7 -> no done pulse.
- i_start during LOAD beat 4 -> load completes normally, o_start_err=1. Next start clears o_start_err and o_ops.
- Async reset: drive i_rst_n=0 mid-LOAD between clock edges -> all outputs zero immediately. After release, i_valid without start is ignored and o_ops stays 0.

Source files
------------

// File: rtl/operand_loader_if.sv
// Operand loader bus interface.
//
// Groups the load handshake and operand bus between a feeding master and
// operand_loader. Signal names keep the i_/o_ prefixes as seen from the
// loader (slave) side.
//
// Handshake: a beat on i_chunk is transferred on a rising clock edge where
// i_valid && o_ready. o_ready depends only on loader state, never on
// i_valid, so a master may assert i_valid and hold it until acceptance.
//
// Signals:
//   i_start      begin a load (honoured only when the loader is idle)
//   i_abort      cancel an in-progress load
//   i_valid      i_chunk holds a valid beat
//   i_chunk      NUM_OPS lanes of CHUNK_W bits, lane j = [j*CHUNK_W +: CHUNK_W]
//   o_ready      loader accepts a beat this cycle
//   o_busy       loader is in LOAD or DONE
//   o_beat_cnt   beats accepted in the current load
//   o_ops        assembled operands, operand j = [j*DATA_W +: DATA_W]
//   o_load_done  one-cycle pulse when the operand set is complete
//   o_start_err  sticky flag: start requested while busy
interface operand_loader_if #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 4,
  parameter int NUM_OPS = 5
) ();
  localparam int CNT_W = $clog2(DATA_W / CHUNK_W + 1);

  logic                        i_start;
  logic                        i_abort;
  logic                        i_valid;
  logic [NUM_OPS*CHUNK_W-1:0]  i_chunk;
  logic                        o_ready;
  logic                        o_busy;
  logic [CNT_W-1:0]            o_beat_cnt;
  logic [NUM_OPS*DATA_W-1:0]   o_ops;
  logic                        o_load_done;
  logic                        o_start_err;

  modport master (
    output i_start, i_abort, i_valid, i_chunk,
    input  o_ready, o_busy, o_beat_cnt, o_ops, o_load_done, o_start_err
  );

  modport slave (
    input  i_start, i_abort, i_valid, i_chunk,
    output o_ready, o_busy, o_beat_cnt, o_ops, o_load_done, o_start_err
  );
endinterface

// File: rtl/operand_loader.sv
// Operand loader: assembles NUM_OPS operands of DATA_W bits from narrow
// CHUNK_W-bit lanes, one chunk per operand per accepted beat, and presents
// them to Control with a one-cycle o_load_done pulse.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        operand_loader_if.slave (handshake, chunks, operands, status)
//   dbg_state  current FSM state (0 = IDLE, 1 = LOAD, 2 = DONE)
//
// MSB_FIRST = 0 puts beat 0 into the lowest chunk of every operand;
// MSB_FIRST = 1 puts beat 0 into the highest chunk.
module operand_loader #(
  parameter int DATA_W    = 32,
  parameter int CHUNK_W   = 4,
  parameter int NUM_OPS   = 5,
  parameter int MSB_FIRST = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  operand_loader_if.slave  bus,
  output logic [1:0]       dbg_state
);
  localparam int BEATS = DATA_W / CHUNK_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_OPS*DATA_W-1:0]  ops_q, ops_d;
  logic                       err_q, err_d;
  logic                       busy_q;
  logic                       done_q;
  logic [CNT_W-1:0]           pos;

  // Chunk slot written by the current beat.
  always_comb begin
    pos = cnt_q;
    if (MSB_FIRST != 0) begin
      pos = CNT_W'(BEATS - 1) - cnt_q;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          ops_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (bus.i_start) begin
          err_d = 1'b1;
        end
        // Abort has priority over a beat, including the final one.
        if (bus.i_abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          ops_d   = '0;
        end else if (bus.i_valid) begin
          for (int j = 0; j < NUM_OPS; j++) begin
            ops_d[j*DATA_W + int'(pos)*CHUNK_W +: CHUNK_W] =
              bus.i_chunk[j*CHUNK_W +: CHUNK_W];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.i_start) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // busy and done are registered from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ops_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.o_ready     = (state_q == LOAD);
  assign bus.o_busy      = busy_q;
  assign bus.o_beat_cnt  = cnt_q;
  assign bus.o_ops       = ops_q;
  assign bus.o_load_done = done_q;
  assign bus.o_start_err = err_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: one LSB-first and one MSB-first instance
// driven with identical stimulus.
module tb_operand_loader;
  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 4;
  localparam int NUM_OPS = 5;
  localparam int CW      = NUM_OPS * CHUNK_W;
  localparam int OW      = NUM_OPS * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_loader_if #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .NUM_OPS(NUM_OPS)) if_l ();
  operand_loader_if #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .NUM_OPS(NUM_OPS)) if_m ();
  logic [1:0] st_l, st_m;

  operand_loader #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .NUM_OPS(NUM_OPS), .MSB_FIRST(0))
    dut_l (.i_clk(clk), .i_rst_n(rst_n), .bus(if_l.slave), .dbg_state(st_l));
  operand_loader #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .NUM_OPS(NUM_OPS), .MSB_FIRST(1))
    dut_m (.i_clk(clk), .i_rst_n(rst_n), .bus(if_m.slave), .dbg_state(st_m));

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  always @(posedge clk) begin
    if (if_l.o_load_done) done_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic a, input logic v, input logic [CW-1:0] ch);
    if_l.i_start = s; if_l.i_abort = a; if_l.i_valid = v; if_l.i_chunk = ch;
    if_m.i_start = s; if_m.i_abort = a; if_m.i_valid = v; if_m.i_chunk = ch;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat n of the standard pattern: lane0 = 8-n, lanes1..3 = F, lane4 = n.
  function automatic logic [CW-1:0] beat(input int n);
    logic [3:0] l0, l4;
    l0 = 4'(8 - n);
    l4 = 4'(n);
    return {l4, 4'hF, 4'hF, 4'hF, l0};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ops(input string tag, input logic [OW-1:0] obs,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3,
                         input logic [31:0] e4);
    chk({tag, "_op0"}, 64'(obs[0*DATA_W +: DATA_W]), 64'(e0));
    chk({tag, "_op1"}, 64'(obs[1*DATA_W +: DATA_W]), 64'(e1));
    chk({tag, "_op2"}, 64'(obs[2*DATA_W +: DATA_W]), 64'(e2));
    chk({tag, "_op3"}, 64'(obs[3*DATA_W +: DATA_W]), 64'(e3));
    chk({tag, "_op4"}, 64'(obs[4*DATA_W +: DATA_W]), 64'(e4));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},  64'(if_l.o_busy), 64'd0);
    chk({tag, "_ready"}, 64'(if_l.o_ready), 64'd0);
    chk({tag, "_done"},  64'(if_l.o_load_done), 64'd0);
    chk({tag, "_cnt"},   64'(if_l.o_beat_cnt), 64'd0);
    chk({tag, "_ops"},   64'(if_l.o_ops == '0), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses0;
    drive(1'b0, 1'b0, 1'b0, '0);

    // Reset state
    #2;
    chk_idle_zero("rst");
    chk("rst_err", 64'(if_l.o_start_err), 64'd0);
    chk("rst_state", 64'(st_l), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Load A: plain load, both orders
    pulses0 = done_pulses;
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    chk("a_ready", 64'(if_l.o_ready), 64'd1);
    chk("a_busy", 64'(if_l.o_busy), 64'd1);
    chk("a_cnt0", 64'(if_l.o_beat_cnt), 64'd0);
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 1'b0, 1'b1, beat(n));
      tick();
      if (n < 7) chk("a_nodone", 64'(if_l.o_load_done), 64'd0);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("a_done", 64'(if_l.o_load_done), 64'd1);
    chk("a_cnt8", 64'(if_l.o_beat_cnt), 64'd8);
    chk("a_ready_done", 64'(if_l.o_ready), 64'd0);
    chk("a_busy_done", 64'(if_l.o_busy), 64'd1);
    chk_ops("a_lsb", if_l.o_ops, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h76543210);
    chk_ops("a_msb", if_m.o_ops, 32'h87654321, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01234567);
    tick();
    chk("a_done_off", 64'(if_l.o_load_done), 64'd0);
    chk("a_cnt_back", 64'(if_l.o_beat_cnt), 64'd0);
    chk("a_busy_off", 64'(if_l.o_busy), 64'd0);
    chk("a_ops_hold", 64'(if_l.o_ops[31:0]), 64'h12345678);
    tick();
    chk("a_pulses", 64'(done_pulses - pulses0), 64'd1);

    // Load B: back-to-back start, stall 3 cycles after beat 2
    pulses0 = done_pulses;
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    chk("b_start_clears", 64'(if_l.o_ops == '0), 64'd1);
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 1'b0, 1'b1, beat(n));
      tick();
      if (n == 2) begin
        drive(1'b0, 1'b0, 1'b0, beat(3));
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("b_stall_cnt", 64'(if_l.o_beat_cnt), 64'd3);
          chk("b_stall_ready", 64'(if_l.o_ready), 64'd1);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("b_done", 64'(if_l.o_load_done), 64'd1);
    chk_ops("b_lsb", if_l.o_ops, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h76543210);
    tick();
    tick();
    chk("b_pulses", 64'(done_pulses - pulses0), 64'd1);

    // Load C: abort together with beat 5
    pulses0 = done_pulses;
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 1'b0, 1'b1, beat(n));
      tick();
    end
    chk("c_cnt5", 64'(if_l.o_beat_cnt), 64'd5);
    drive(1'b0, 1'b1, 1'b1, beat(5));
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk_idle_zero("c_abort");
    chk("c_msb_ops", 64'(if_m.o_ops == '0), 64'd1);
    tick();
    tick();
    chk("c_pulses", 64'(done_pulses - pulses0), 64'd0);

    // Load D: abort together with final beat
    pulses0 = done_pulses;
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int n = 0; n < 7; n++) begin
      drive(1'b0, 1'b0, 1'b1, beat(n));
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, beat(7));
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk_idle_zero("d_abort");
    tick();
    tick();
    chk("d_pulses", 64'(done_pulses - pulses0), 64'd0);

    // Load E: start during beat 4 is ignored but flagged
    pulses0 = done_pulses;
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int n = 0; n < 8; n++) begin
      drive(n == 4, 1'b0, 1'b1, beat(n));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("e_done", 64'(if_l.o_load_done), 64'd1);
    chk("e_err", 64'(if_l.o_start_err), 64'd1);
    chk_ops("e_lsb", if_l.o_ops, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h76543210);
    tick();
    chk("e_err_sticky", 64'(if_l.o_start_err), 64'd1);
    chk("e_pulses", 64'(done_pulses - pulses0), 64'd1);
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    chk("e_err_clear", 64'(if_l.o_start_err), 64'd0);
    chk("e_ops_clear", 64'(if_l.o_ops == '0), 64'd1);

    // Start plus abort in LOAD: abort wins, error flagged
    drive(1'b0, 1'b0, 1'b1, beat(0));
    tick();
    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("f_busy", 64'(if_l.o_busy), 64'd0);
    chk("f_err", 64'(if_l.o_start_err), 64'd1);
    chk("f_ops", 64'(if_l.o_ops == '0), 64'd1);

    // Asynchronous reset mid-load, between clock edges
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b0, 1'b1, beat(n));
      tick();
    end
    chk("g_pre_cnt", 64'(if_l.o_beat_cnt), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero("g_async");
    chk("g_err", 64'(if_l.o_start_err), 64'd0);
    chk("g_msb_ops", 64'(if_m.o_ops == '0), 64'd1);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, beat(4));
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk_idle_zero("g_valid_ignored");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
